// File: rtl/seq_mac.sv
// rtl/seq_mac.sv - sequential radix-2 shift-add multiply-accumulate unit; optional SEQ_MAC_SAT_EN selects a saturating accumulator with a sticky ovf flag
module seq_mac #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 2*WIDTH+8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [WIDTH-1:0]       a,
  input  logic [WIDTH-1:0]       b,
  input  logic                   sgn,
  input  logic                   acc_en,
  input  logic                   clr,
  output logic                   ready,
  output logic                   done,
  output logic [2*WIDTH-1:0]     prod,
  output logic [ACC_WIDTH-1:0]   acc,
  output logic                   ovf
);

  localparam int PW  = 2*WIDTH;
  localparam int CW  = $clog2(WIDTH+1);
  localparam int AW1 = ACC_WIDTH+1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH-1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q;
  logic [PW-1:0]          mcand_q;
  logic [WIDTH-1:0]       mplier_q;
  logic [PW-1:0]          part_q;
  logic                   sgn_q;
  logic                   acc_en_q;
  logic [PW-1:0]          prod_q;
  logic [ACC_WIDTH-1:0]   acc_q;
  logic                   ovf_q;
  logic                   done_q;

  logic [PW-1:0]          part_d;
  logic [ACC_WIDTH-1:0]   prod_ext;
  logic [ACC_WIDTH-1:0]   acc_base;
  logic [ACC_WIDTH-1:0]   acc_d;
  logic                   clamp;

  // State register; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: accept start in IDLE, leave BUSY after the MSB iteration, DONE lasts one cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_BUSY;
      S_BUSY:  if (cnt_q == LAST) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: ready while idle; done, prod, acc and ovf come straight from registers
  always_comb begin
    ready = (state_q == S_IDLE);
    done  = done_q;
    prod  = prod_q;
    acc   = acc_q;
    ovf   = ovf_q;
  end

  // One shift-add step; the MSB step of a signed multiply subtracts (its weight is negative)
  always_comb begin
    part_d = part_q;
    if (mplier_q[0]) begin
      if (sgn_q && (cnt_q == LAST)) begin
        part_d = part_q - mcand_q;
      end else begin
        part_d = part_q + mcand_q;
      end
    end
  end

  // Extend the finished product to accumulator width and pick the addend base
  always_comb begin
    if (sgn_q) begin
      prod_ext = ACC_WIDTH'($signed(part_q));
    end else begin
      prod_ext = ACC_WIDTH'(part_q);
    end
    acc_base = acc_en_q ? acc_q : '0;
  end

`ifdef SEQ_MAC_SAT_EN
  logic [ACC_WIDTH:0] sum_x;

  // Accumulate one bit wider than acc, then clamp to the signed or unsigned range
  always_comb begin
    clamp = 1'b0;
    if (sgn_q) begin
      sum_x = AW1'($signed(acc_base)) + AW1'($signed(prod_ext));
      acc_d = sum_x[ACC_WIDTH-1:0];
      if (sum_x[ACC_WIDTH] != sum_x[ACC_WIDTH-1]) begin
        clamp = 1'b1;
        acc_d = sum_x[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                 : {1'b0, {(ACC_WIDTH-1){1'b1}}};
      end
    end else begin
      sum_x = {1'b0, acc_base} + {1'b0, prod_ext};
      acc_d = sum_x[ACC_WIDTH-1:0];
      if (sum_x[ACC_WIDTH]) begin
        clamp = 1'b1;
        acc_d = '1;
      end
    end
  end
`else
  // Wrapping accumulate; overflow is never reported
  always_comb begin
    acc_d = acc_base + prod_ext;
    clamp = 1'b0;
  end
`endif

  // Datapath: operand latch on accept, iterate while BUSY, commit results on the DONE edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      part_q   <= '0;
      sgn_q    <= 1'b0;
      acc_en_q <= 1'b0;
      prod_q   <= '0;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= (state_q == S_DONE);
      case (state_q)
        S_IDLE: begin
          if (clr) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
          end
          if (start) begin
            mcand_q  <= {{WIDTH{sgn & b[WIDTH-1]}}, b};
            mplier_q <= a;
            part_q   <= '0;
            sgn_q    <= sgn;
            acc_en_q <= acc_en;
            cnt_q    <= '0;
          end
        end
        S_BUSY: begin
          part_q   <= part_d;
          mcand_q  <= {mcand_q[PW-2:0], 1'b0};
          mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
          cnt_q    <= cnt_q + CW'(1);
        end
        S_DONE: begin
          prod_q <= part_q;
          if (clr) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
          end else begin
            acc_q <= acc_d;
            ovf_q <= ovf_q | clamp;
          end
        end
        default: begin
          cnt_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mac.sv
// tb/tb_seq_mac.sv - directed self-checking bench for seq_mac with WIDTH=4, ACC_WIDTH=8
module tb_seq_mac;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       sgn;
  logic       acc_en;
  logic       clr;
  logic       ready;
  logic       done;
  logic [7:0] prod;
  logic [7:0] acc;
  logic       ovf;

  int checks;
  int errors;

  seq_mac #(.WIDTH(4), .ACC_WIDTH(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .sgn    (sgn),
    .acc_en (acc_en),
    .clr    (clr),
    .ready  (ready),
    .done   (done),
    .prod   (prod),
    .acc    (acc),
    .ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a negedge with ready=1. Returns the cycle index in which done was seen
  // (accept cycle = 0), or 0 on timeout. Leaves the bench at that done-cycle negedge.
  task automatic run_op(input logic s, input logic [3:0] aa, input logic [3:0] bb,
                        input logic en, input logic clr_at_start, input logic perturb,
                        input logic clr_in_done, output int lat);
    sgn = s; a = aa; b = bb; acc_en = en; start = 1'b1; clr = clr_at_start;
    @(posedge clk);
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      start = perturb && (n <= 5);
      clr   = (perturb && (n <= 4)) || (clr_in_done && (n == 5));
      if (perturb && (n <= 5)) begin
        a = 4'($urandom); b = 4'($urandom); sgn = ~sgn; acc_en = ~acc_en;
      end
      if (done) begin
        lat = n;
        break;
      end
    end
    start = 1'b0;
    clr   = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; sgn = 1'b0; acc_en = 1'b0; clr = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ready); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (prod !== 8'h00) begin errors++; $display("FAIL reset_prod: got %h want 00", prod); end
    checks++; if (acc !== 8'h00) begin errors++; $display("FAIL reset_acc: got %h want 00", acc); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int lat;
    run_op(1'b1, 4'd4, 4'd6, 1'b0, 1'b0, 1'b0, 1'b0, lat);
    checks++; if (lat !== 6) begin errors++; $display("FAIL basic_latency: got %0d want 6", lat); end
    checks++; if (prod !== 8'h18) begin errors++; $display("FAIL basic_prod: got %h want 18", prod); end
    checks++; if (acc !== 8'h18) begin errors++; $display("FAIL basic_acc: got %h want 18", acc); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL basic_ready_at_done: got %b want 1", ready); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_one_cycle: got %b want 0", done); end
    checks++; if (prod !== 8'h18) begin errors++; $display("FAIL basic_prod_hold: got %h want 18", prod); end
  endtask

  task automatic test_signed;
    logic [3:0] ta [5] = '{4'hC, 4'h4, 4'hC, 4'hF, 4'h8};
    logic [3:0] tb [5] = '{4'h6, 4'hA, 4'hA, 4'hF, 4'h8};
    logic [7:0] tp [5] = '{8'hE8, 8'hE8, 8'h18, 8'h01, 8'h40};
    int lat;
    for (int i = 0; i < 5; i++) begin
      run_op(1'b1, ta[i], tb[i], 1'b0, 1'b0, 1'b0, 1'b0, lat);
      checks++;
      if (prod !== tp[i]) begin
        errors++; $display("FAIL signed_prod[%0d]: got %h want %h", i, prod, tp[i]);
      end
      checks++;
      if (acc !== tp[i]) begin
        errors++; $display("FAIL signed_acc[%0d]: got %h want %h", i, acc, tp[i]);
      end
    end
  endtask

  task automatic test_unsigned;
    int lat;
    run_op(1'b0, 4'd15, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0, lat);
    checks++; if (prod !== 8'hE1) begin errors++; $display("FAIL unsigned_prod: got %h want e1", prod); end
    checks++; if (acc !== 8'd225) begin errors++; $display("FAIL unsigned_acc: got %0d want 225", acc); end
  endtask

  task automatic test_back_to_back;
    int lat;
    run_op(1'b1, 4'd7, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0, lat);
    checks++; if (acc !== 8'h31) begin errors++; $display("FAIL b2b_acc1: got %h want 31", acc); end
    run_op(1'b1, 4'd7, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0, lat);
    checks++; if (lat !== 6) begin errors++; $display("FAIL b2b_latency: got %0d want 6", lat); end
    checks++; if (acc !== 8'h62) begin errors++; $display("FAIL b2b_acc2: got %h want 62", acc); end
    run_op(1'b1, 4'd7, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0, lat);
    checks++; if (prod !== 8'h31) begin errors++; $display("FAIL b2b_prod: got %h want 31", prod); end
`ifdef SEQ_MAC_SAT_EN
    checks++; if (acc !== 8'h7F) begin errors++; $display("FAIL b2b_acc3: got %h want 7f", acc); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL b2b_ovf: got %b want 1", ovf); end
`else
    checks++; if (acc !== 8'h93) begin errors++; $display("FAIL b2b_acc3: got %h want 93", acc); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL b2b_ovf: got %b want 0", ovf); end
`endif
  endtask

  task automatic test_clr_idle;
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    checks++; if (acc !== 8'h00) begin errors++; $display("FAIL clr_idle_acc: got %h want 00", acc); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL clr_idle_ovf: got %b want 0", ovf); end
  endtask

  task automatic test_ignore_busy;
    int lat;
    int seen;
    run_op(1'b0, 4'd2, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, lat);
    run_op(1'b0, 4'd3, 4'd5, 1'b1, 1'b0, 1'b1, 1'b0, lat);
    checks++; if (lat !== 6) begin errors++; $display("FAIL busy_latency: got %0d want 6", lat); end
    checks++; if (prod !== 8'h0F) begin errors++; $display("FAIL busy_prod: got %h want 0f", prod); end
    checks++; if (acc !== 8'd21) begin errors++; $display("FAIL busy_acc: got %0d want 21", acc); end
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL busy_stray_done: got %0d want 0", seen); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL busy_idle_after: got %b want 1", ready); end
  endtask

  task automatic test_clr_done;
    int lat;
    run_op(1'b0, 4'd5, 4'd5, 1'b1, 1'b0, 1'b0, 1'b1, lat);
    checks++; if (prod !== 8'h19) begin errors++; $display("FAIL clr_done_prod: got %h want 19", prod); end
    checks++; if (acc !== 8'h00) begin errors++; $display("FAIL clr_done_acc: got %h want 00", acc); end
  endtask

  task automatic test_clr_start;
    int lat;
    run_op(1'b0, 4'd4, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, lat);
    checks++; if (acc !== 8'h20) begin errors++; $display("FAIL clr_start_pre: got %h want 20", acc); end
    run_op(1'b0, 4'd2, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, lat);
    checks++; if (acc !== 8'h06) begin errors++; $display("FAIL clr_start_acc: got %h want 06", acc); end
    checks++; if (prod !== 8'h06) begin errors++; $display("FAIL clr_start_prod: got %h want 06", prod); end
  endtask

  task automatic test_reset_busy;
    int lat;
    int seen;
    sgn = 1'b1; a = 4'd3; b = 4'd3; acc_en = 1'b1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rst_busy_ready: got %b want 1", ready); end
    checks++; if (acc !== 8'h00) begin errors++; $display("FAIL rst_busy_acc: got %h want 00", acc); end
    checks++; if (prod !== 8'h00) begin errors++; $display("FAIL rst_busy_prod: got %h want 00", prod); end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rst_busy_no_done: got %0d want 0", seen); end
    run_op(1'b1, 4'd4, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0, lat);
    checks++; if (lat !== 6) begin errors++; $display("FAIL rst_next_latency: got %0d want 6", lat); end
    checks++; if (acc !== 8'h18) begin errors++; $display("FAIL rst_next_acc: got %h want 18", acc); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset;
    test_basic;
    test_signed;
    test_unsigned;
    test_back_to_back;
    test_clr_idle;
    test_ignore_busy;
    test_clr_done;
    test_clr_start;
    test_reset_busy;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_mac.md
SEQ_MAC -- requirements
Module: seq_mac

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 Parameter ACC_WIDTH, default 2*WIDTH+8, accumulator width; SHALL be >= 2*WIDTH.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request a new operation; sampled only when ready=1.
REQ-006 a, b  input  WIDTH each  multiplier and multiplicand; latched when start is accepted.
REQ-007 sgn  input  1  1 = two's-complement operands, 0 = unsigned; latched with a, b.
REQ-008 acc_en  input  1  1 = add product to accumulator, 0 = overwrite accumulator; latched with a, b.
REQ-009 clr  input  1  synchronous accumulator clear.
REQ-010 ready  output  1  high when idle and able to accept start.
REQ-011 done  output  1  one-cycle pulse marking a completed operation.
REQ-012 prod  output  2*WIDTH  exact product of the last completed operation.
REQ-013 acc  output  ACC_WIDTH  accumulator value.
REQ-014 ovf  output  1  sticky accumulator-overflow flag (see Configuration).

Function
REQ-015 The FSM SHALL have three states, IDLE, BUSY and DONE, with transitions IDLE->BUSY on accepted start, BUSY->DONE after WIDTH iterations, and DONE->IDLE unconditionally.
REQ-016 Start accepted (start=1 in IDLE): latch a, b, sgn and acc_en; iteration counter=0; ready falls at that edge.
REQ-017 BUSY: one radix-2 shift-add iteration per cycle, exactly WIDTH cycles; in signed mode the MSB iteration subtracts the multiplicand (two's-complement correction).
REQ-018 DONE edge: prod takes the final product; acc updates; done=1 and ready=1 for the following cycle; done is high for exactly one cycle.
REQ-019 Latency: done is high in cycle WIDTH+2 counted from the start-accept edge (cycle 0); back-to-back start is accepted on the cycle done is high.
REQ-020 prod: sign-extended semantics per latched sgn; exact for all operand pairs, including the most-negative value times itself.
REQ-021 acc update: acc_en=1 -> acc + ext(prod); acc_en=0 -> ext(prod); ext is sign- or zero-extension per latched sgn.
REQ-022 prod and acc hold their values between operations.
REQ-023 start while BUSY or DONE SHALL be ignored; input changes while BUSY SHALL not affect the result.
REQ-024 clr in IDLE zeroes acc and ovf at that edge; clr together with start SHALL clear first, then accept start.
REQ-025 clr while BUSY is ignored; clr on the DONE edge takes precedence, so acc=0 and the product is still written to prod.

Reset
REQ-026 rst_n low SHALL asynchronously force IDLE, ready=1, done=0, prod=0, acc=0, ovf=0 and counter=0.
REQ-027 Reset during BUSY or DONE SHALL abort the operation with no done pulse; after release the block is idle.

Configuration
REQ-028 Macro SEQ_MAC_SAT_EN defined: the acc update saturates to the signed max/min (sgn=1) or to 0..2^ACC_WIDTH-1 (sgn=0), and ovf is set on any clamp, sticky until clr or reset.
REQ-029 Macro SEQ_MAC_SAT_EN undefined: acc wraps modulo 2^ACC_WIDTH and ovf is tied to 0.

Verification (WIDTH=4, ACC_WIDTH=8 unless stated)
REQ-030 sgn=1, a=4, b=6, acc_en=0 -> prod=0x18 and done 6 cycles after accept.
REQ-031 Signed sign cases: a=-4,b=6 -> prod=0xE8; a=4,b=-6 -> 0xE8; a=-4,b=-6 -> 0x18; a=-1,b=-1 -> 0x01; a=-8,b=-8 -> 0x40.
REQ-032 Unsigned: sgn=0, a=15, b=15 -> prod=0xE1; acc=225 with acc_en=0.
REQ-033 Accumulate: sgn=1, a=7, b=7 issued three times back-to-back (acc_en=0, then 1, 1) -> SEQ_MAC_SAT_EN defined: acc=127, ovf=1; undefined: acc=0x93, ovf=0.
REQ-034 Reset: rst_n pulsed low at cycle 3 of BUSY -> no done pulse, acc=0 and ready=1 immediately; the next start completes normally.
REQ-035 clr and start asserted in the same IDLE cycle with acc=0x20, a=2, b=3, acc_en=1 -> final acc=0x06.
